// File: rtl/pmod_mic_sampler_if.sv
// Bundle of control, status and serial-pin signals for pmod_mic_sampler.
// master = the side that triggers reads and drives MISO; slave = the sampler.
interface pmod_mic_sampler_if #(
    parameter int N_CH   = 1,
    parameter int DATA_W = 12
);
    logic                     read;
    logic                     auto_en;
    logic                     clr_ovr;
    logic [N_CH-1:0]          MISO;
    logic                     SCLK;
    logic                     CS;
    logic [N_CH*DATA_W-1:0]   audio;
    logic                     new_data;
    logic                     busy;
    logic                     frame_err;
    logic                     overrun;

    modport master (
        output read, auto_en, clr_ovr, MISO,
        input  SCLK, CS, audio, new_data, busy, frame_err, overrun
    );

    modport slave (
        input  read, auto_en, clr_ovr, MISO,
        output SCLK, CS, audio, new_data, busy, frame_err, overrun
    );
endinterface

// File: rtl/pmod_mic_sampler.sv
// Serial ADC frame reader for PMOD microphone modules.
// One frame = LEAD_BITS leading zeros followed by DATA_W data bits, MSB first,
// captured on every SCLK rise from N_CH MISO lines in parallel.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | CS high, SCLK high, waiting for read or an auto-timer tick
// S_SETUP | CS low, SCLK high for CLK_DIV cycles before the first falling edge
// S_SHIFT | FRAME SCLK periods (low half then high half), capture on rise
// S_QUIET | CS high for QUIET_CYC cycles between frames
module pmod_mic_sampler #(
    parameter int DATA_W        = 12,
    parameter int LEAD_BITS     = 4,
    parameter int N_CH          = 1,
    parameter int CLK_DIV       = 2,
    parameter int QUIET_CYC     = 4,
    parameter int SAMPLE_PERIOD = 2000,
    parameter int TWOS_COMP     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    pmod_mic_sampler_if.slave    mic
);

    localparam int FRAME   = LEAD_BITS + DATA_W;
    localparam int CNT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(FRAME + 1);
    localparam int TW      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [BW-1:0]                bits_q, bits_d;
    logic                         phase_q, phase_d;
    logic [N_CH-1:0][FRAME-1:0]   sh_q, sh_d;
    logic [N_CH*DATA_W-1:0]       audio_q, audio_d;
    logic                         new_data_q, new_data_d;
    logic                         frame_err_q, frame_err_d;
    logic                         overrun_q, overrun_d;
    logic [TW-1:0]                timer_q, timer_d;

    logic                         tick;
    logic                         trigger;
    logic                         cnt_zero;
    logic                         capture;
    logic                         frame_done;
    logic                         lead_err;
    logic [DATA_W-1:0]            word_v;

    assign tick       = mic.auto_en && (timer_q == TW'(SAMPLE_PERIOD - 1));
    assign trigger    = mic.read || tick;
    assign cnt_zero   = (cnt_q == '0);
    // Rising SCLK happens at the end of a low half; the frame ends after the
    // high half of the last period.
    assign capture    = (state_q == S_SHIFT) && !phase_q && cnt_zero;
    assign frame_done = (state_q == S_SHIFT) && phase_q && cnt_zero && (bits_q == '0);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bits_q      <= '0;
            phase_q     <= 1'b0;
            sh_q        <= '0;
            audio_q     <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bits_q      <= bits_d;
            phase_q     <= phase_d;
            sh_q        <= sh_d;
            audio_q     <= audio_d;
            new_data_q  <= new_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            timer_q     <= timer_d;
        end
    end

    // Next state plus the half-period / quiet down-counter and period counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(CLK_DIV - 1);
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_SHIFT;
                    cnt_d   = CW'(CLK_DIV - 1);
                    phase_d = 1'b0;
                    bits_d  = BW'(FRAME - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SHIFT: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!phase_q) begin
                    cnt_d   = CW'(CLK_DIV - 1);
                    phase_d = 1'b1;
                end else if (bits_q == '0) begin
                    state_d = S_QUIET;
                    cnt_d   = CW'(QUIET_CYC - 1);
                    phase_d = 1'b0;
                end else begin
                    cnt_d   = CW'(CLK_DIV - 1);
                    phase_d = 1'b0;
                    bits_d  = bits_q - BW'(1);
                end
            end
            S_QUIET: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shift capture, frame delivery, auto timer and sticky overrun.
    always_comb begin
        sh_d        = sh_q;
        audio_d     = audio_q;
        frame_err_d = frame_err_q;
        new_data_d  = 1'b0;
        lead_err    = 1'b0;
        word_v      = '0;
        if (capture) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                sh_d[ch] = {sh_q[ch][FRAME-2:0], mic.MISO[ch]};
            end
        end
        if (frame_done) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                word_v = sh_q[ch][DATA_W-1:0];
                if (TWOS_COMP != 0) begin
                    word_v[DATA_W-1] = ~word_v[DATA_W-1];
                end
                audio_d[ch*DATA_W +: DATA_W] = word_v;
                lead_err = lead_err | (|(sh_q[ch] >> DATA_W));
            end
            frame_err_d = lead_err;
            new_data_d  = 1'b1;
        end

        if (!mic.auto_en || (timer_q == TW'(SAMPLE_PERIOD - 1))) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // A tick lost while a frame is in flight wins over a clear request.
        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (mic.clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Pin and status decode from the registered state.
    always_comb begin
        mic.busy      = (state_q != S_IDLE);
        mic.CS        = (state_q == S_IDLE) || (state_q == S_QUIET);
        mic.SCLK      = !((state_q == S_SHIFT) && !phase_q);
        mic.audio     = audio_q;
        mic.new_data  = new_data_q;
        mic.frame_err = frame_err_q;
        mic.overrun   = overrun_q;
    end

endmodule

// File: doc/pmod_mic_sampler.md
PMOD_MIC_SAMPLER -- requirements
Module: pmod_mic_sampler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled only on the rising edge of clk.
REQ-002 Parameter DATA_W, 12, sample bits per channel.
REQ-003 Parameter LEAD_BITS, 4, leading bits per frame (expected zero) before the MSB.
REQ-004 Parameter N_CH, 1, number of MISO lines sharing SCLK/CS.
REQ-005 Parameter CLK_DIV, 2, clk cycles per SCLK half-period (>=1).
REQ-006 Parameter QUIET_CYC, 4, minimum clk cycles CS stays high between frames (>=1).
REQ-007 Parameter SAMPLE_PERIOD, 2000, clk cycles between auto triggers.
REQ-008 Parameter TWOS_COMP, 0; 1 = invert each channel's MSB on output (offset binary to two's complement).
REQ-009 clk  in  1  system clock.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 read  in  1  single-shot trigger, level-sampled in IDLE.
REQ-012 auto_en  in  1  enables free-running sampling from the internal period timer.
REQ-013 clr_ovr  in  1  clears overrun.
REQ-014 MISO  in  N_CH  serial data, bit i = channel i.
REQ-015 SCLK  out  1  serial clock, idles high.
REQ-016 CS  out  1  chip select, active low.
REQ-017 audio  out  N_CH*DATA_W  channel i in bits [i*DATA_W +: DATA_W].
REQ-018 new_data  out  1  one-cycle valid strobe for audio.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 frame_err  out  1  high for the frame just delivered if any leading bit on any channel was 1; updated with new_data.
REQ-021 overrun  out  1  sticky: a trigger was lost.

Function
REQ-022 FSM states: IDLE, SETUP, SHIFT, QUIET.
REQ-023 IDLE -> SETUP when a trigger is sampled; a trigger is read=1 or an auto tick. On entry: CS=0, SCLK=1.
REQ-024 SETUP lasts CLK_DIV cycles, then -> SHIFT.
REQ-025 SHIFT runs FRAME=LEAD_BITS+DATA_W SCLK periods, each CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-026 On each SCLK low-to-high transition, all MISO bits are registered, MSB first per channel.
REQ-027 After the high half of the last period: CS=1, audio/frame_err updated, new_data=1 for exactly one cycle, state -> QUIET.
REQ-028 QUIET lasts QUIET_CYC cycles with CS=1 and SCLK=1, then -> IDLE.
REQ-029 Latency from trigger sampled to new_data: 1 + CLK_DIV + 2*CLK_DIV*FRAME cycles.
REQ-030 audio holds its value until the next new_data.
REQ-031 Leading bits are not stored in audio; only the last DATA_W captured bits per channel are output.
REQ-032 Auto timer is a modulo-SAMPLE_PERIOD counter, running only while auto_en=1 and cleared to 0 while auto_en=0; it ticks when the count wraps from SAMPLE_PERIOD-1.
REQ-033 A trigger (read=1 or tick) arriving while busy=1 is dropped; a dropped auto tick sets overrun. read while busy is ignored without setting overrun.
REQ-034 clr_ovr clears overrun; if clr_ovr and an overrun event occur in the same cycle, overrun=1.
REQ-035 read and tick in the same IDLE cycle start one frame only; no overrun.
REQ-036 A trigger held high continuously restarts a frame immediately after each QUIET.

Reset
REQ-037 While rst=1: state=IDLE, CS=1, SCLK=1, audio=0, new_data=0, busy=0, frame_err=0, overrun=0, timer=0, shift registers=0.
REQ-038 rst asserted mid-frame aborts the frame on the next edge: CS=1, no new_data is produced, and audio keeps its reset value of 0.

Verification
REQ-039 Single shot (defaults): read pulse; MISO drives 0000 then 0xCDE -> CS low 1 cycle after read, 16 SCLK rises, audio=0xCDE, new_data one cycle at latency 1+2+64=67, frame_err=0.
REQ-040 TWOS_COMP=1: capture 0x800 -> audio=0x000; capture 0x7FF -> audio=0xFFF.
REQ-041 N_CH=2: ch0 stream 0x123, ch1 stream 0xABC in the same frame -> audio=0xABC123.
REQ-042 A leading bit set to 1 in bit position 2, data 0x555 -> audio=0x555, frame_err=1; the next clean frame gives frame_err=0.
REQ-043 auto_en=1, SAMPLE_PERIOD=50 (below frame length) -> at least one tick is dropped, overrun=1; clr_ovr pulse with auto_en=0 -> overrun=0.
REQ-044 rst asserted at SCLK rise 8 -> CS=1 next cycle, no new_data, audio=0; a following read completes normally.
